// File: rtl/scale_mode_pkg.sv
// Shared mode codes, sequencer states and the mode-to-geometry mapping
// for the scaled-image display path.
package scale_mode_pkg;

  localparam logic [2:0] MODE_REPL  = 3'b000;
  localparam logic [2:0] MODE_DECIM = 3'b001;
  localparam logic [2:0] MODE_ZOOM  = 3'b010;
  localparam logic [2:0] MODE_RESET = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StDebounce,
    StWaitVb,
    StReq,
    StCopy,
    StWaitFrame
  } state_e;

  typedef struct packed {
    logic [9:0] w;
    logic [9:0] h;
    logic [9:0] x_off;
    logic [9:0] y_off;
  } geom_t;

  function automatic geom_t mode_geom(input logic [2:0]  m,
                                      input int unsigned img_w,
                                      input int unsigned img_h,
                                      input int unsigned fator,
                                      input int unsigned scr_w,
                                      input int unsigned scr_h);
    geom_t       g;
    int unsigned w;
    int unsigned h;
    logic [10:0] dx;
    logic [10:0] dy;
    case (m)
      MODE_REPL, MODE_ZOOM: begin
        w = img_w * fator;
        h = img_h * fator;
      end
      MODE_DECIM: begin
        w = img_w / fator;
        h = img_h / fator;
      end
      default: begin
        w = img_w;
        h = img_h;
      end
    endcase
    // Centring offsets are taken from an 11-bit difference, then halved into 10 bits.
    dx      = 11'(scr_w - w);
    dy      = 11'(scr_h - h);
    g.w     = 10'(w);
    g.h     = 10'(h);
    g.x_off = dx[10:1];
    g.y_off = dy[10:1];
    return g;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus stability counter for the 3-bit mode switches.
// `changed` pulses once when the candidate has been stable for DEB_CYCLES cycles.
module sw_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       clk_50MHz,
  input  logic       vga_reset,
  input  logic [2:0] sw,
  input  logic       restart,
  output logic [2:0] sw_sync,
  output logic [2:0] value,
  output logic       changed
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  logic [2:0]      s1_q;
  logic [2:0]      s2_q;
  logic [2:0]      cand_q;
  logic [2:0]      cand_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_ff @(posedge clk_50MHz or posedge vga_reset) begin
    if (vga_reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= sw;
      s2_q   <= s1_q;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (restart || (s2_q != cand_q)) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CntW'(DEB_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign sw_sync = s2_q;
  assign value   = cand_q;
  assign changed = !restart && (s2_q == cand_q) && (cnt_q == CntW'(DEB_CYCLES - 1));

endmodule

// File: rtl/scale_mode_sequencer.sv
// Sequences display mode changes: debounce switches, blank at vsync, run the
// ROM-to-framebuffer copy handshake, then publish the new geometry at a frame edge.
module scale_mode_sequencer
  import scale_mode_pkg::*;
#(
  parameter int unsigned IMG_W      = 160,
  parameter int unsigned IMG_H      = 120,
  parameter int unsigned FATOR      = 2,
  parameter int unsigned SCR_W      = 640,
  parameter int unsigned SCR_H      = 480,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned TIMEOUT    = 2000000
) (
  input  logic       clk_50MHz,
  input  logic       vga_reset,
  input  logic [2:0] sw,
  input  logic       vsync_n,
  input  logic       copy_done,
  output logic       copy_req,
  output logic [2:0] mode,
  output logic [9:0] img_w,
  output logic [9:0] img_h,
  output logic [9:0] x_off,
  output logic [9:0] y_off,
  output logic       display_en,
  output logic       busy,
  output logic       err
);

  localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);
  localparam geom_t       RstGeom = mode_geom(MODE_RESET, IMG_W, IMG_H, FATOR, SCR_W, SCR_H);

  state_e          state_q, state_d;
  logic            vs_s1_q, vs_s2_q, vs_prev_q;
  logic            done_s1_q, done_s2_q, done_prev_q;
  logic [1:0]      boot_q;
  logic [2:0]      tgt_q, tgt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            copy_req_q, copy_req_d;
  logic            display_en_q, display_en_d;
  logic            err_q, err_d;
  logic [2:0]      mode_q, mode_d;
  geom_t           geom_q, geom_d;
  geom_t           pub_geom;
  logic [2:0]      sw_sync, deb_value;
  logic            deb_changed, deb_restart;
  logic            vs_fall, done_rise, tmo_hit;

  sw_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sw_debounce (
    .clk_50MHz(clk_50MHz),
    .vga_reset(vga_reset),
    .sw       (sw),
    .restart  (deb_restart),
    .sw_sync  (sw_sync),
    .value    (deb_value),
    .changed  (deb_changed)
  );

  assign vs_fall   = vs_prev_q & ~vs_s2_q;
  assign done_rise = done_s2_q & ~done_prev_q;
  assign tmo_hit   = ((state_q == StReq) || (state_q == StCopy)) &&
                     (tmo_q == TmoW'(TIMEOUT - 1));
  assign pub_geom  = mode_geom(tgt_q, IMG_W, IMG_H, FATOR, SCR_W, SCR_H);

  always_ff @(posedge clk_50MHz or posedge vga_reset) begin
    if (vga_reset) begin
      state_q      <= StWaitVb;
      vs_s1_q      <= 1'b1;
      vs_s2_q      <= 1'b1;
      vs_prev_q    <= 1'b1;
      done_s1_q    <= 1'b1;
      done_s2_q    <= 1'b1;
      done_prev_q  <= 1'b1;
      boot_q       <= '0;
      tgt_q        <= MODE_REPL;
      tmo_q        <= '0;
      copy_req_q   <= 1'b0;
      display_en_q <= 1'b0;
      err_q        <= 1'b0;
      mode_q       <= MODE_RESET;
      geom_q       <= RstGeom;
    end else begin
      state_q      <= state_d;
      vs_s1_q      <= vsync_n;
      vs_s2_q      <= vs_s1_q;
      vs_prev_q    <= vs_s2_q;
      done_s1_q    <= copy_done;
      done_s2_q    <= done_s1_q;
      done_prev_q  <= done_s2_q;
      if (boot_q != 2'd3) boot_q <= boot_q + 2'd1;
      tgt_q        <= tgt_d;
      tmo_q        <= tmo_d;
      copy_req_q   <= copy_req_d;
      display_en_q <= display_en_d;
      err_q        <= err_d;
      mode_q       <= mode_d;
      geom_q       <= geom_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (sw_sync != mode_q) state_d = StDebounce;
      StDebounce:  if (deb_changed) state_d = (deb_value == mode_q) ? StIdle : StWaitVb;
      StWaitVb:    if (vs_fall) state_d = StReq;
      // tmo_q != 0 keeps the request up for at least two cycles even on an early ack.
      StReq: begin
        if (tmo_hit) state_d = StIdle;
        else if (!done_s2_q && (tmo_q != '0)) state_d = StCopy;
      end
      StCopy: begin
        if (tmo_hit) state_d = StIdle;
        else if (done_rise) state_d = StWaitFrame;
      end
      StWaitFrame: if (vs_fall) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    tgt_d        = tgt_q;
    tmo_d        = tmo_q;
    copy_req_d   = copy_req_q;
    display_en_d = display_en_q;
    err_d        = err_q;
    mode_d       = mode_q;
    geom_d       = geom_q;
    deb_restart  = 1'b0;
    // The first synchronized switch value becomes the initial copy target.
    if (boot_q == 2'd2) tgt_d = sw_sync;
    unique case (state_q)
      StIdle:     deb_restart = (sw_sync != mode_q);
      StDebounce: if (deb_changed) tgt_d = deb_value;
      StWaitVb: begin
        if (vs_fall) begin
          display_en_d = 1'b0;
          copy_req_d   = 1'b1;
          tmo_d        = '0;
        end
      end
      StReq, StCopy: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_hit) begin
          err_d        = 1'b1;
          copy_req_d   = 1'b0;
          display_en_d = 1'b1;
          tmo_d        = '0;
        end else if ((state_q == StReq) && !done_s2_q && (tmo_q != '0)) begin
          copy_req_d = 1'b0;
        end
      end
      StWaitFrame: begin
        if (vs_fall) begin
          mode_d       = tgt_q;
          geom_d       = pub_geom;
          display_en_d = 1'b1;
        end
      end
      default: ;
    endcase
    busy = (state_q != StIdle);
  end

  assign copy_req   = copy_req_q;
  assign display_en = display_en_q;
  assign err        = err_q;
  assign mode       = mode_q;
  assign img_w      = geom_q.w;
  assign img_h      = geom_q.h;
  assign x_off      = geom_q.x_off;
  assign y_off      = geom_q.y_off;

endmodule

// File: tb/tb_scale_mode_sequencer.sv
// Randomized self-checking bench: vsync and copier models drive the sequencer,
// published geometry is compared against an arithmetic reference of the mode table.
module tb_scale_mode_sequencer;

  localparam int unsigned IMG_W = 160, IMG_H = 120, FATOR = 2, SCR_W = 640, SCR_H = 480;
  localparam int unsigned DEB = 16, TMO = 200;
  localparam int VS_PERIOD = 60, VS_LOW = 4;

  logic       clk_50MHz = 1'b0;
  logic       vga_reset = 1'b1;
  logic [2:0] sw = 3'b000;
  logic       vsync_n = 1'b1;
  logic       copy_done = 1'b1;
  logic       copy_req, display_en, busy, err;
  logic [2:0] mode;
  logic [9:0] img_w, img_h, x_off, y_off;

  scale_mode_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .FATOR(FATOR), .SCR_W(SCR_W), .SCR_H(SCR_H),
    .DEB_CYCLES(DEB), .TIMEOUT(TMO)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .vga_reset (vga_reset),
    .sw        (sw),
    .vsync_n   (vsync_n),
    .copy_done (copy_done),
    .copy_req  (copy_req),
    .mode      (mode),
    .img_w     (img_w),
    .img_h     (img_h),
    .x_off     (x_off),
    .y_off     (y_off),
    .display_en(display_en),
    .busy      (busy),
    .err       (err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fall_cyc = -1000;
  int req_rises = 0;
  int last_rise_cyc = 0;
  bit ack_en = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference geometry straight from the mode table.
  function automatic logic [39:0] ref_geom(input int m);
    int w, h;
    if (m == 0 || m == 2) begin
      w = IMG_W * FATOR;
      h = IMG_H * FATOR;
    end else if (m == 1) begin
      w = IMG_W / FATOR;
      h = IMG_H / FATOR;
    end else begin
      w = IMG_W;
      h = IMG_H;
    end
    return {10'(w), 10'(h), 10'((SCR_W - w) / 2), 10'((SCR_H - h) / 2)};
  endfunction

  task automatic check_display(input string tag, input int m);
    logic [39:0] e;
    e = ref_geom(m);
    check_eq({tag, "_mode"}, 64'(mode), 64'(m));
    check_eq({tag, "_img_w"}, 64'(img_w), 64'(e[39:30]));
    check_eq({tag, "_img_h"}, 64'(img_h), 64'(e[29:20]));
    check_eq({tag, "_x_off"}, 64'(x_off), 64'(e[19:10]));
    check_eq({tag, "_y_off"}, 64'(y_off), 64'(e[9:0]));
    check_eq({tag, "_display_en"}, 64'(display_en), 64'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_copy_req"}, 64'(copy_req), 64'(0));
    check_eq({tag, "_display_en"}, 64'(display_en), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(1));
    check_eq({tag, "_err"}, 64'(err), 64'(0));
    check_eq({tag, "_mode"}, 64'(mode), 64'(7));
    check_eq({tag, "_img_w"}, 64'(img_w), 64'(160));
    check_eq({tag, "_img_h"}, 64'(img_h), 64'(120));
    check_eq({tag, "_x_off"}, 64'(x_off), 64'(240));
    check_eq({tag, "_y_off"}, 64'(y_off), 64'(180));
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? copy_req : err;
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic lvl, input int budget);
    int n = 0;
    while (sig(sel) !== lvl && n < budget) begin
      @(negedge clk_50MHz);
      n++;
    end
    if (n >= budget) check_eq({tag, "_timeout"}, 64'(sig(sel)), 64'(lvl));
  endtask

  task automatic wait_publish(input string tag, input int m, input int budget);
    int n = 0;
    while (!(display_en === 1'b1 && mode === 3'(m)) && n < budget) begin
      @(negedge clk_50MHz);
      n++;
    end
    check_eq({tag, "_publish_in_time"}, 64'(n < budget), 64'(1));
  endtask

  task automatic set_sw(input logic [2:0] v);
    @(posedge clk_50MHz);
    #1 sw = v;
  endtask

  initial forever begin
    @(posedge clk_50MHz);
    cyc++;
  end

  initial forever begin
    repeat (VS_PERIOD - VS_LOW) @(posedge clk_50MHz);
    #1 vsync_n = 1'b0;
    fall_cyc = cyc;
    repeat (VS_LOW) @(posedge clk_50MHz);
    #1 vsync_n = 1'b1;
  end

  // Copier model: acknowledges by dropping copy_done, finishes by raising it.
  initial forever begin
    @(negedge clk_50MHz);
    if (copy_req && ack_en && copy_done) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_50MHz);
      copy_done = 1'b0;
      repeat ($urandom_range(12, 40)) @(negedge clk_50MHz);
      copy_done = 1'b1;
    end
  end

  initial begin
    logic        prev_req = 1'b0;
    logic        prev_de = 1'b0;
    logic [39:0] prev_geom = '0;
    logic [39:0] geom;
    forever begin
      @(negedge clk_50MHz);
      geom = {img_w, img_h, x_off, y_off};
      if (!vga_reset) begin
        if (copy_req && !prev_req) begin
          req_rises++;
          last_rise_cyc = cyc;
          check_eq("req_latency", 64'((cyc - fall_cyc) inside {[3:4]}), 64'(1));
        end
        if (!copy_req && prev_req)
          check_eq("req_min_width", 64'((cyc - last_rise_cyc) >= 2), 64'(1));
        if (prev_de && display_en) check_eq("geom_hold", 64'(geom), 64'(prev_geom));
      end
      prev_req  = copy_req;
      prev_de   = display_en;
      prev_geom = geom;
    end
  end

  initial begin
    repeat (60000) @(posedge clk_50MHz);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d, required finish earlier", cyc);
    $fatal(1);
  end

  initial begin
    int rises0, tog, r_cyc, cur, m;
    repeat (3) @(negedge clk_50MHz);
    check_reset_vals("rst");
    @(posedge clk_50MHz);
    #3 vga_reset = 1'b0;

    // Initial image copy after reset.
    rises0 = req_rises;
    wait_publish("t1", 0, 400);
    check_display("t1", 0);
    check_eq("t1_one_req", 64'(req_rises - rises0), 64'(1));
    check_eq("t1_busy", 64'(busy), 64'(0));

    rises0 = req_rises;
    set_sw(3'b001);
    wait_publish("t2", 1, 400);
    check_display("t2", 1);
    check_eq("t2_one_req", 64'(req_rises - rises0), 64'(1));

    // Bouncing switches must not start a copy until they settle.
    rises0 = req_rises;
    for (int i = 0; i < 12; i++) begin
      set_sw((i % 2 == 0) ? 3'b010 : 3'b001);
      repeat (7) @(posedge clk_50MHz);
    end
    set_sw(3'b010);
    tog = cyc;
    wait_publish("t3", 2, 400);
    check_display("t3", 2);
    check_eq("t3_one_req", 64'(req_rises - rises0), 64'(1));
    check_eq("t3_deb_delay", 64'((last_rise_cyc - tog) >= int'(DEB)), 64'(1));

    // No acknowledge: timeout, sticky err, old picture restored.
    ack_en = 1'b0;
    set_sw(3'b101);
    wait_for("t4_req", 0, 1'b1, 400);
    r_cyc = cyc;
    wait_for("t4_err", 1, 1'b1, 400);
    check_eq("t4_err_time", 64'((cyc - r_cyc) inside {[TMO:TMO + 1]}), 64'(1));
    check_eq("t4_copy_req", 64'(copy_req), 64'(0));
    check_display("t4", 2);
    ack_en = 1'b1;
    wait_publish("t6", 5, 1500);
    check_display("t6", 5);
    check_eq("t4_err_sticky", 64'(err), 64'(1));

    // Reset in the middle of a copy.
    set_sw(3'b000);
    wait_for("t5_req", 0, 1'b1, 400);
    wait_for("t5_ack", 0, 1'b0, 100);
    repeat (2) @(negedge clk_50MHz);
    check_eq("t5_in_copy", 64'({busy, display_en, copy_done}), 64'(3'b100));
    @(posedge clk_50MHz);
    #5 vga_reset = 1'b1;
    #1 check_reset_vals("t5_rst");
    @(posedge vsync_n);
    #3 vga_reset = 1'b0;
    rises0 = req_rises;
    wait_for("t5_rereq", 0, 1'b1, 2 * VS_PERIOD + 10);
    check_eq("t5_rereq_count", 64'(req_rises - rises0), 64'(1));
    wait_publish("t5", 0, 400);
    check_display("t5", 0);
    check_eq("t5_err_cleared", 64'(err), 64'(0));

    // Random mode walk.
    cur = 0;
    for (int k = 0; k < 5; k++) begin
      m = int'($urandom_range(0, 7));
      if (m == cur) m = (m + 1) % 8;
      rises0 = req_rises;
      set_sw(3'(m));
      wait_publish("rnd", m, 400);
      check_display("rnd", m);
      check_eq("rnd_one_req", 64'(req_rises - rises0), 64'(1));
      cur = m;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
